// File: rtl/select_adder_pkg.sv
// Shared defaults, stage-count helper and the per-stage register bundle for the pipelined carry-select adder.
package select_adder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_BLOCK = 4;
   localparam int DEFAULT_SEG   = 2;
   localparam int MAX_WIDTH     = 64;

   function automatic int nstg(input int width, input int block, input int seg);
      return width / (block * seg);
   endfunction

   // Fields are sized for the widest supported datapath; instances use the low WIDTH bits.
   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [MAX_WIDTH-1:0] sum;
      logic [MAX_WIDTH-1:0] a_skew;
      logic [MAX_WIDTH-1:0] b_skew;
   } stage_t;

endpackage

// File: rtl/pipelined_select_adder_if.sv
// Valid/ready operand and result bundle of the pipelined carry-select adder.
interface pipelined_select_adder_if #(
   parameter int WIDTH = select_adder_pkg::DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/select_adder_block.sv
// One carry-select slice: sums for carry-in 0 and 1 are formed in parallel, the real carry picks one.
module select_adder_block
   import select_adder_pkg::*;
#(
   parameter int BLOCK = DEFAULT_BLOCK
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] s,
   output logic             cout
);

   logic [BLOCK:0] sum0;
   logic [BLOCK:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + (BLOCK+1)'(1);

   assign {cout, s} = cin ? sum1 : sum0;

endmodule

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor, SEG slices per stage, global-stall valid/ready handshake.
// Signed overflow output is built only when SELECT_ADDER_OVF_EN is defined; otherwise ovf is tied to 0.
module pipelined_select_adder
   import select_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int BLOCK = DEFAULT_BLOCK,
   parameter int SEG   = DEFAULT_SEG
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_select_adder_if.slave bus
);

   localparam int SW   = BLOCK * SEG;
   localparam int NSTG = nstg(WIDTH, BLOCK, SEG);

   if ((WIDTH % SW) != 0 || WIDTH > MAX_WIDTH || NSTG < 1) begin : g_bad_cfg
      $error("pipelined_select_adder: WIDTH=%0d must be a nonzero multiple of BLOCK*SEG=%0d and <= %0d",
             WIDTH, SW, MAX_WIDTH);
   end

   stage_t st_q [NSTG];
   stage_t st_d [NSTG];
   logic   adv;

   // One global stall: every stage moves together whenever the output slot is free or being drained.
   assign adv          = !st_q[NSTG-1].valid || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = st_q[NSTG-1].valid;
   assign bus.s        = st_q[NSTG-1].sum[WIDTH-1:0];
   assign bus.cout     = st_q[NSTG-1].carry;

`ifdef SELECT_ADDER_OVF_EN
   logic ovf_d;
   logic ovf_q;
`endif

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic [WIDTH-1:0] a_cur;
      logic [WIDTH-1:0] b_cur;
      logic [WIDTH-1:0] sum_cur;
      logic [WIDTH-1:0] sum_nxt;
      logic [SW-1:0]    seg_sum;
      logic             c_cur;
      logic             v_cur;

      if (k == 0) begin : g_src_in
         assign a_cur   = bus.a;
         assign b_cur   = bus.sub ? ~bus.b : bus.b;
         assign c_cur   = bus.sub | bus.cin;
         assign sum_cur = '0;
         assign v_cur   = bus.in_valid & adv;
      end else begin : g_src_reg
         assign a_cur   = st_q[k-1].a_skew[WIDTH-1:0];
         assign b_cur   = st_q[k-1].b_skew[WIDTH-1:0];
         assign c_cur   = st_q[k-1].carry;
         assign sum_cur = st_q[k-1].sum[WIDTH-1:0];
         assign v_cur   = st_q[k-1].valid;
      end

      // Each slice carry is its own net so the ripple through the stage stays acyclic per signal.
      for (genvar j = 0; j < SEG; j++) begin : g_seg
         logic ci;
         logic co;

         if (j == 0) begin : g_first
            assign ci = c_cur;
         end else begin : g_next
            assign ci = g_seg[j-1].co;
         end

         select_adder_block #(.BLOCK(BLOCK)) u_blk (
            .a    (a_cur[k*SW + j*BLOCK +: BLOCK]),
            .b    (b_cur[k*SW + j*BLOCK +: BLOCK]),
            .cin  (ci),
            .s    (seg_sum[j*BLOCK +: BLOCK]),
            .cout (co)
         );
      end

      // NOTE: the default copy comes first so every bit of sum_nxt is written on every pass (no latch).
      always_comb begin
         sum_nxt                = sum_cur;
         sum_nxt[k*SW +: SW]    = seg_sum;
      end

      assign st_d[k] = '{valid:  v_cur,
                         carry:  g_seg[SEG-1].co,
                         sum:    MAX_WIDTH'(sum_nxt),
                         a_skew: MAX_WIDTH'(a_cur),
                         b_skew: MAX_WIDTH'(b_cur)};

`ifdef SELECT_ADDER_OVF_EN
      if (k == NSTG-1) begin : g_ovf
         assign ovf_d = (a_cur[WIDTH-1] == b_cur[WIDTH-1]) && (sum_nxt[WIDTH-1] != a_cur[WIDTH-1]);
      end
`endif
   end

   // NOTE: data fields are cleared with the valid bits so S and cout read 0 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTG; i++) begin
            st_q[i] <= '0;
         end
      end else if (adv) begin
         // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
         st_q <= st_d;
      end
   end

`ifdef SELECT_ADDER_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Self-checking bench: directed corner cases, backpressured random stream and a 32-bit / mid-flight reset run.
module tb_pipelined_select_adder;

`ifdef SELECT_ADDER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] s;
      logic        cout;
      logic        ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst16;
   logic rst32;
   int   n_pass = 0;
   int   n_fail = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   pipelined_select_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_select_adder_if #(.WIDTH(32)) bus32 ();

   pipelined_select_adder #(.WIDTH(16), .BLOCK(4), .SEG(2)) u_dut16 (
      .clk (clk),
      .rst (rst16),
      .bus (bus16)
   );

   pipelined_select_adder #(.WIDTH(32), .BLOCK(4), .SEG(2)) u_dut32 (
      .clk (clk),
      .rst (rst32),
      .bus (bus32)
   );

   // Reference: unsigned sum for S/cout, true signed result range test for overflow.
   function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
      longint unsigned modv;
      longint unsigned tot;
      longint          sa;
      longint          sb;
      longint          tru;
      longint          half;
      res_t            r;
      modv = 64'd1 << w;
      half = longint'(modv / 2);
      sa   = (a >= modv / 2) ? longint'(a) - longint'(modv) : longint'(a);
      sb   = (b >= modv / 2) ? longint'(b) - longint'(modv) : longint'(b);
      if (sub) begin
         tot    = a + (modv - b);
         r.cout = (a >= b);
         tru    = sa - sb;
      end else begin
         tot    = a + b + 64'(cin);
         r.cout = (tot >= modv);
         tru    = sa + sb + longint'(cin);
      end
      r.s   = tot % modv;
      r.ovf = OVF_EN && ((tru >= half) || (tru < -half));
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one op on the 16-bit unit, confirm it is not early, then compare against directed values.
   task automatic single16(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub,
                           input logic [15:0] exp_s, input logic exp_cout, input logic exp_ovf);
      bus16.a         = a;
      bus16.b         = b;
      bus16.cin       = cin;
      bus16.sub       = sub;
      bus16.in_valid  = 1'b1;
      bus16.out_ready = 1'b1;
      #1;
      check1({tag, "_in_ready"}, bus16.in_ready, 1'b1);
      step();
      bus16.in_valid = 1'b0;
      check1({tag, "_not_early"}, bus16.out_valid, 1'b0);
      step();
      check1({tag, "_valid"}, bus16.out_valid, 1'b1);
      check({tag, "_s"}, 64'(bus16.s), 64'(exp_s));
      check1({tag, "_cout"}, bus16.cout, exp_cout);
      check1({tag, "_ovf"}, bus16.ovf, exp_ovf & OVF_EN);
      step();
      check1({tag, "_popped"}, bus16.out_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] st_a [8];
      logic [15:0] st_b [8];
      logic        st_cin [8];
      logic        st_sub [8];
      bit          ready_pat [4];
      res_t        q [$];
      res_t        exp_r;
      int          pushed;
      int          popped;
      int          cyc;
      bit          prev_stall;
      logic [15:0] prev_s;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rsub;

      rst16 = 1'b1;
      rst32 = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
      bus16.out_ready = 1'b1;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
      bus32.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst16 = 1'b0;
      rst32 = 1'b0;
      #1;

      // Reset state
      check1("rst_out_valid", bus16.out_valid, 1'b0);
      check("rst_s", 64'(bus16.s), 64'd0);
      check1("rst_cout", bus16.cout, 1'b0);
      check1("rst_ovf", bus16.ovf, 1'b0);
      check1("rst_in_ready", bus16.in_ready, 1'b1);
      check1("rst32_out_valid", bus32.out_valid, 1'b0);
      check1("rst32_in_ready", bus32.in_ready, 1'b1);
      step();

      // Directed corner cases
      single16("add_cin", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
      single16("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      single16("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single16("sub_ign_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // Backpressured random stream
      for (int i = 0; i < 8; i++) begin
         st_a[i]   = 16'($urandom);
         st_b[i]   = 16'($urandom);
         st_cin[i] = 1'($urandom);
         st_sub[i] = 1'($urandom);
      end
      ready_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
      pushed     = 0;
      popped     = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_s     = '0;
      while (popped < 8 && cyc < 200) begin
         bus16.out_ready = ready_pat[cyc % 4];
         bus16.in_valid  = (pushed < 8);
         if (pushed < 8) begin
            bus16.a   = st_a[pushed];
            bus16.b   = st_b[pushed];
            bus16.cin = st_cin[pushed];
            bus16.sub = st_sub[pushed];
         end
         #1;
         check1("stream_in_ready", bus16.in_ready, !(bus16.out_valid && !bus16.out_ready));
         if (prev_stall) begin
            check1("stall_hold_valid", bus16.out_valid, 1'b1);
            check("stall_hold_s", 64'(bus16.s), 64'(prev_s));
         end
         if (bus16.out_valid && bus16.out_ready) begin
            check1("stream_no_dup", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
               exp_r = q.pop_front();
               check("stream_s", 64'(bus16.s), exp_r.s);
               check1("stream_cout", bus16.cout, exp_r.cout);
               check1("stream_ovf", bus16.ovf, exp_r.ovf);
            end
            popped++;
         end
         if (bus16.in_valid && bus16.in_ready) begin
            q.push_back(model(16, 64'(st_a[pushed]), 64'(st_b[pushed]), st_cin[pushed], st_sub[pushed]));
            pushed++;
         end
         prev_stall = bus16.out_valid && !bus16.out_ready;
         prev_s     = bus16.s;
         @(posedge clk);
         #1;
         cyc++;
      end
      check("stream_popped", 64'(popped), 64'd8);
      check("stream_leftover", 64'(q.size()), 64'd0);
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check1("stream_drained", bus16.out_valid, 1'b0);
         step();
      end

      // 32-bit, four stages: latency of 3 edges after acceptance
      bus32.a = 32'h7FFF_FFFF; bus32.b = 32'h0000_0001; bus32.cin = 1'b0; bus32.sub = 1'b0;
      bus32.in_valid = 1'b1;
      step();
      bus32.in_valid = 1'b0;
      check1("w32_lat_e0", bus32.out_valid, 1'b0);
      step();
      check1("w32_lat_e1", bus32.out_valid, 1'b0);
      step();
      check1("w32_lat_e2", bus32.out_valid, 1'b0);
      step();
      check1("w32_valid", bus32.out_valid, 1'b1);
      check("w32_s", 64'(bus32.s), 64'h8000_0000);
      check1("w32_cout", bus32.cout, 1'b0);
      check1("w32_ovf", bus32.ovf, OVF_EN);
      step();
      check1("w32_popped", bus32.out_valid, 1'b0);

      // Mid-flight reset with three ops in the pipe
      for (int i = 0; i < 3; i++) begin
         bus32.a = $urandom; bus32.b = $urandom; bus32.cin = 1'($urandom); bus32.sub = 1'($urandom);
         bus32.in_valid = 1'b1;
         step();
      end
      bus32.in_valid = 1'b0;
      rst32 = 1'b1;
      #1;
      check1("mid_rst_now", bus32.out_valid, 1'b0);
      step();
      check1("mid_rst_next", bus32.out_valid, 1'b0);
      rst32 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check1("mid_rst_no_stale", bus32.out_valid, 1'b0);
      end

      // Post-reset random subtract/add on the wide unit against the model
      ra   = $urandom;
      rb   = $urandom;
      rsub = 1'($urandom);
      exp_r = model(32, 64'(ra), 64'(rb), 1'b1, rsub);
      bus32.a = ra; bus32.b = rb; bus32.cin = 1'b1; bus32.sub = rsub;
      bus32.in_valid = 1'b1;
      step();
      bus32.in_valid = 1'b0;
      repeat (3) step();
      check1("w32_rand_valid", bus32.out_valid, 1'b1);
      check("w32_rand_s", 64'(bus32.s), exp_r.s);
      check1("w32_rand_cout", bus32.cout, exp_r.cout);
      check1("w32_rand_ovf", bus32.ovf, exp_r.ovf);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipelined_select_adder.md
# pipelined_select_adder

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides. Operands are split into BLOCK-bit slices, and each slice precomputes carry-in-0 and carry-in-1 results. Groups of SEG slices form one pipeline stage, so throughput is one operation per cycle at any width. The block is the datapath-width successor to the fixed 16-bit combinational carry-select adder and feeds the ALU result path.

## Interface
- WIDTH, 16: operand and result width. Must be a multiple of BLOCK*SEG, otherwise elaboration fails with $error.
- BLOCK, 4: bits per carry-select slice.
- SEG, 2: slices per pipeline stage. NSTG = WIDTH/(BLOCK*SEG) is the number of stages.
- Clk  in  1: single clock; all state updates on its rising edge.
- Reset  in  1: asynchronous, active-high.
- in_valid  in  1: A, B, sub, cin are valid.
- in_ready  out  1: block accepts an operation this cycle.
- A, B  in  WIDTH: operands.
- cin  in  1: carry-in. Ignored when sub=1.
- sub  in  1: 1 selects A − B.
- out_valid  out  1: S, cout, ovf hold a valid result.
- out_ready  in  1: downstream accepts the result.
- S  out  WIDTH: sum or difference.
- cout  out  1: carry out of MSB. For subtraction this is the inverted borrow.
- ovf  out  1: signed overflow (see Configuration).

## Operation
- Effective operands: Be = sub ? ~B : B; c0 = sub ? 1 : cin.
- Slice i computes {c,s} for carry-in 0 and carry-in 1 in parallel. The real incoming carry muxes the pair; the selected carry chains to slice i+1.
- Stage k processes slices k*SEG … k*SEG+SEG−1.
  - Stage k registers: finished low sum bits, the carry into the next stage, and the still-unprocessed high bits of A and Be (skew registers).
  - The last stage registers the full S, cout and ovf.
- All arithmetic is modulo 2^WIDTH. cout is bit WIDTH of A + Be + c0.
- Handshake uses a global stall:
  - adv = !out_valid || out_ready
  - in_ready = adv
  - All stage registers and valid bits load only when adv=1.
  - The stage-0 valid bit loads in_valid & in_ready.
- While out_valid=1 and out_ready=0, S, cout and ovf hold stable and no operation is accepted.
- Bubbles propagate as valid=0. Bubble data contents are don't-care but must never raise out_valid.

## Timing
- Reset, asynchronous: all stage valid bits, out_valid, S, cout and ovf clear to 0. in_ready reads 1 in the first cycle after reset deassert.
- Latency: an operation accepted at edge t shows out_valid=1 after edge t+NSTG−1 (NSTG=2 gives 1 cycle after acceptance, i.e. visible in cycle t+1). This holds when there are no stalls.
- Throughput: one operation per cycle when out_ready is held at 1.
- Simultaneous output pop and input push in one cycle is allowed: both occur, and the pipeline advances.
- Reset asserted mid-operation discards every in-flight result, with no partial output.
- in_ready is combinational from out_valid and out_ready only; there is no path from in_valid.
- No combinational path runs from A, B or cin to any output.

## Configuration
- SELECT_ADDER_OVF_EN defined:
  - ovf = (A[W−1] == Be[W−1]) && (S[W−1] != A[W−1]).
  - ovf is registered alongside S and follows the same stall rules.
- SELECT_ADDER_OVF_EN undefined: the ovf port exists but is tied to 0, and no overflow logic is synthesised.

## Structure
- Package select_adder_pkg:
  - default WIDTH/BLOCK/SEG localparams
  - function nstg(width, block, seg)
  - typedef for the per-stage register bundle (valid, partial sum, carry, skewed operand bits)
- Sub-module select_adder_block:
  - one BLOCK-bit dual ripple slice
  - ports A, B, cin → S, cout
  - contains both precomputed chains and the output mux
- The top generates NSTG×SEG instances of select_adder_block, plus the stage registers and handshake logic.

## Test plan
- Reset check (defaults, OVF_EN defined): deassert Reset → out_valid=0, S=0, cout=0, ovf=0, in_ready=1.
- Addition with carry-in: A=16'h00FF, B=16'h0001, cin=1, sub=0 → S=16'h0101, cout=0, ovf=0. Result appears 1 edge after acceptance.
- Subtraction with overflow: A=16'h8000, B=16'h0001, sub=1 → S=16'h7FFF, cout=1, ovf=1.
- Carry ripple across all slices and stages: A=16'hFFFF, B=16'h0001, cin=0 → S=16'h0000, cout=1, ovf=0.
- Back-to-back streaming with backpressure:
  - Push 8 random ops on consecutive cycles while out_ready toggles 1,0,0,1.
  - Required: results in order, matching a scoreboard.
  - Required: S held stable while stalled, no drop or duplicate, in_ready=0 exactly when out_valid && !out_ready.
- Parameter sweep and mid-operation reset:
  - WIDTH=32, BLOCK=4, SEG=2 (NSTG=4): A=32'h7FFFFFFF + B=1 → S=32'h80000000, ovf=1, latency 3 edges.
  - Assert Reset with 3 ops in flight → out_valid=0 next cycle, and no stale result ever emerges.
